// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and helpers for the MEM pipeline stage
package mem_stage_pkg;

   localparam int REGS_ADDR_W = 5;
   localparam int REGS_DATA_W = 32;
   localparam int BUS_W       = 32;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LBU  = 4'd2,
      MEM_LH   = 4'd3,
      MEM_LHU  = 4'd4,
      MEM_LW   = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// rtl/mem_stage_load_store_align.sv - big-endian lane select, store replication, load extension
module load_store_align
   import mem_stage_pkg::*;
(
   input  logic [3:0]       mem_op_i,
   input  logic [1:0]       offset_i,
   input  logic [BUS_W-1:0] store_data_i,
   input  logic [BUS_W-1:0] rdata_i,
   output logic [3:0]       byte_sel_o,
   output logic [BUS_W-1:0] wdata_o,
   output logic [BUS_W-1:0] load_data_o,
   output logic             misaligned_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Byte offset 0 is the most significant lane.
   always_comb begin
      lane_b = rdata_i[31:24];
      case (offset_i)
         2'd0:    lane_b = rdata_i[31:24];
         2'd1:    lane_b = rdata_i[23:16];
         2'd2:    lane_b = rdata_i[15:8];
         default: lane_b = rdata_i[7:0];
      endcase
      lane_h = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
   end

   always_comb begin
      byte_sel_o   = 4'b0000;
      wdata_o      = store_data_i;
      load_data_o  = rdata_i;
      misaligned_o = 1'b0;
      case (mem_op_e'(mem_op_i))
         MEM_LB:  load_data_o = {{24{lane_b[7]}}, lane_b};
         MEM_LBU: load_data_o = {24'd0, lane_b};
         MEM_LH: begin
            misaligned_o = offset_i[0];
            load_data_o  = {{16{lane_h[15]}}, lane_h};
         end
         MEM_LHU: begin
            misaligned_o = offset_i[0];
            load_data_o  = {16'd0, lane_h};
         end
         MEM_LW: begin
            misaligned_o = |offset_i;
            load_data_o  = rdata_i;
         end
         MEM_SB: begin
            byte_sel_o = 4'b1000 >> offset_i;
            wdata_o    = {4{store_data_i[7:0]}};
         end
         MEM_SH: begin
            misaligned_o = offset_i[0];
            byte_sel_o   = offset_i[1] ? 4'b0011 : 4'b1100;
            wdata_o      = {2{store_data_i[15:0]}};
         end
         MEM_SW: begin
            misaligned_o = |offset_i;
            byte_sel_o   = 4'b1111;
            wdata_o      = store_data_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-bus access FSM with ack timeout
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ex_write_enable,
   input  logic [REGS_ADDR_W-1:0] ex_write_addr,
   input  logic [REGS_DATA_W-1:0] ex_write_data,
   input  logic [3:0]             ex_mem_op,
   input  logic [BUS_W-1:0]       ex_mem_addr,
   input  logic [BUS_W-1:0]       ex_mem_store_data,
   output logic                   mem_write_enable,
   output logic [REGS_ADDR_W-1:0] mem_write_addr,
   output logic [REGS_DATA_W-1:0] mem_write_data,
   output logic                   bus_req,
   output logic                   bus_we,
   output logic [BUS_W-1:0]       bus_addr,
   output logic [3:0]             bus_byte_sel,
   output logic [BUS_W-1:0]       bus_wdata,
   input  logic [BUS_W-1:0]       bus_rdata,
   input  logic                   bus_ack,
   output logic                   stall_request,
   output logic                   addr_error,
   output logic                   bus_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [BUS_W-1:0]       rdata_q, rdata_d;
   logic [3:0]             op_q, op_d;
   logic [BUS_W-1:0]       addr_q, addr_d;
   logic [BUS_W-1:0]       sdata_q, sdata_d;
   logic                   we_q, we_d;
   logic [REGS_ADDR_W-1:0] waddr_q, waddr_d;
   logic [REGS_DATA_W-1:0] wdata_q, wdata_d;
   logic                   err_q, err_d;

   logic                   req_c, stall_c, addr_err_c, we_c;
   logic [REGS_ADDR_W-1:0] waddr_c;
   logic [REGS_DATA_W-1:0] wdata_c;

   logic [3:0]       act_op;
   logic [BUS_W-1:0] act_addr, act_sdata;
   logic [3:0]       sel;
   logic [BUS_W-1:0] wdata_fmt, load_data;
   logic             misaligned;

   // Once an access launches, the bus is driven from captured copies so it cannot move.
   assign act_op    = (state_q == ST_IDLE) ? ex_mem_op         : op_q;
   assign act_addr  = (state_q == ST_IDLE) ? ex_mem_addr       : addr_q;
   assign act_sdata = (state_q == ST_IDLE) ? ex_mem_store_data : sdata_q;

   load_store_align u_align (
      .mem_op_i     (act_op),
      .offset_i     (act_addr[1:0]),
      .store_data_i (act_sdata),
      .rdata_i      (rdata_q),
      .byte_sel_o   (sel),
      .wdata_o      (wdata_fmt),
      .load_data_o  (load_data),
      .misaligned_o (misaligned)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      op_d       = op_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      we_d       = we_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      err_d      = 1'b0;
      req_c      = 1'b0;
      stall_c    = 1'b0;
      addr_err_c = 1'b0;
      we_c       = ex_write_enable;
      waddr_c    = ex_write_addr;
      wdata_c    = ex_write_data;
      case (state_q)
         ST_IDLE: begin
            if (is_load(ex_mem_op) || is_store(ex_mem_op)) begin
               we_c = 1'b0;
               if (misaligned) begin
                  addr_err_c = 1'b1;
               end else begin
                  req_c   = 1'b1;
                  stall_c = 1'b1;
                  op_d    = ex_mem_op;
                  addr_d  = ex_mem_addr;
                  sdata_d = ex_mem_store_data;
                  we_d    = ex_write_enable;
                  waddr_d = ex_write_addr;
                  wdata_d = ex_write_data;
                  if (bus_ack) begin
                     rdata_d = bus_rdata;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d   = '0;
                     state_d = ST_ACCESS;
                  end
               end
            end
         end
         ST_ACCESS: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            we_c    = 1'b0;
            if (bus_ack) begin
               rdata_d = bus_rdata;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            we_c    = is_load(op_q) & we_q & ~err_q;
            waddr_c = waddr_q;
            wdata_c = is_load(op_q) ? load_data : wdata_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         sdata_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Reset overrides any in-flight access on the control outputs in the same cycle.
   assign bus_req          = req_c & ~reset;
   assign stall_request    = stall_c & ~reset;
   assign addr_error       = addr_err_c & ~reset;
   assign bus_error        = err_q & ~reset;
   assign mem_write_enable = we_c & ~reset;
   assign mem_write_addr   = waddr_c;
   assign mem_write_data   = wdata_c;
   assign bus_we           = bus_req & is_store(act_op);
   assign bus_addr         = {act_addr[BUS_W-1:2], 2'b00};
   assign bus_byte_sel     = sel;
   assign bus_wdata        = wdata_fmt;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for bus_ack before aborting an access.
REQ-002 clock  input  1  clock; all state updates on posedge clock.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 ex_write_enable / ex_write_addr / ex_write_data  input  1/`REGS_ADDR_BUS/`REGS_DATA_BUS  register-write request and ALU result from the EX/MEM buffer.
REQ-005 ex_mem_op  input  4  memory operation: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-006 ex_mem_addr  input  32  byte address of the access.
REQ-007 ex_mem_store_data  input  32  store operand, right-justified.
REQ-008 mem_write_enable / mem_write_addr / mem_write_data  output  1/`REGS_ADDR_BUS/`REGS_DATA_BUS  result to the MEM/WB buffer.
REQ-009 bus_req / bus_we  output  1/1  data-bus request and write strobe.
REQ-010 bus_addr  output  32  word-aligned address (bits 1:0 = 0).
REQ-011 bus_byte_sel  output  4  byte lanes, bit 3 = bits 31:24.
REQ-012 bus_wdata / bus_rdata  output/input  32/32  store and load data.
REQ-013 bus_ack  input  1  access complete; bus_rdata valid in the same cycle.
REQ-014 stall_request  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
REQ-015 addr_error / bus_error  output  1/1  misaligned-access and timeout indications, one cycle each.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 ex_mem_op = NONE: outputs equal the ex_* inputs combinationally; no stall; state stays IDLE.
REQ-018 Valid, aligned memory op in IDLE: bus_req = 1 and stall_request = 1 in the same cycle; next state is ACCESS, or DONE if bus_ack = 1 that cycle.
REQ-019 ACCESS: bus_req, bus_addr, bus_we, bus_byte_sel and bus_wdata are held stable; stall_request = 1; on bus_ack go to DONE.
REQ-020 bus_rdata is latched into an internal register on the cycle bus_ack is asserted.
REQ-021 DONE: bus_req = 0; stall_request = 0; outputs driven from latched data; next state IDLE unconditionally.
REQ-022 Minimum cost of a memory op is one stall cycle, even when bus_ack arrives in the same cycle as the request.
REQ-023 Big-endian lanes: byte offset 0 maps to bits 31:24. Lane selects: SB = 1000/0100/0010/0001 for offsets 0-3; SH = 1100/0011 for offsets 0/2; SW = 1111.
REQ-024 Stores replicate the operand across lanes: byte ×4, halfword ×2.
REQ-025 Loads: LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW passes through; mem_write_data carries the extended value.
REQ-026 Stores force mem_write_enable = 0. Loads use ex_write_enable and ex_write_addr.
REQ-027 Misaligned access (LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0): no bus request, no stall, addr_error = 1 for that cycle, mem_write_enable = 0.
REQ-028 A cycle counter runs in ACCESS. At TIMEOUT_CYCLES without bus_ack: deassert bus_req, pulse bus_error, enter DONE with mem_write_enable = 0.
REQ-029 Counter width is clog2(TIMEOUT_CYCLES+1); the counter clears on entry to ACCESS.

Reset
REQ-030 Reset has priority over all other inputs: state goes to IDLE, counter and latched data clear to 0, bus_req = 0, stall_request = 0, bus_error = 0.
REQ-031 Reset asserted during ACCESS abandons the access; no ack is awaited and no write is produced after reset releases.

Structure
REQ-032 The mem_op encodings, the state encoding and the data-bus width macros belong in the shared utility.v header.
REQ-033 Lane formatting (byte select, store replication, load extension) is a combinational sub-module named load_store_align; the FSM and counter stay in mem_stage.

Verification
REQ-034 ALU op (ex_mem_op = NONE), ex_write_data = 0x1234 -> mem_write_data = 0x1234 in the same cycle; stall_request = 0.
REQ-035 LB at addr 0x103 with bus_rdata = 0x000000F0, bus_ack after 3 cycles -> bus_addr = 0x100, byte_sel = 0001, stall held 3 cycles; in DONE mem_write_data = 0xFFFFFFF0.
REQ-036 SH at addr 0x202 with store data 0xABCD, same-cycle ack -> bus_we = 1, byte_sel = 0011, wdata = 0xABCDABCD; exactly one stall cycle; mem_write_enable = 0.
REQ-037 LW at addr 0x006 -> addr_error = 1, bus_req = 0, stall_request = 0, mem_write_enable = 0.
REQ-038 LW with no ack and TIMEOUT_CYCLES = 16 -> bus_error pulses after 16 ACCESS cycles, then DONE with no write, then IDLE.
REQ-039 Reset in the 2nd ACCESS cycle -> bus_req = 0 and state IDLE the next cycle; a late bus_ack is ignored.
